fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly downstream of the program counter (PC) and upstream of decode.
- Reads the current PC value and issues a read to the synchronous program ROM.
- Latches the returned word into an instruction register and pulses the PC increment.
- Presents the instruction to decode through a valid/ready handshake, and stops in a terminal HALT state when the program space is exhausted.

---
 rtl/fetch_unit_if.sv | 47 ++++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Bundles every non-clock signal of the instruction fetch stage: the PC side,
// the synchronous program ROM side and the decode handshake.
//   master : the fetch unit itself
//            (drives pc_inc, mem_rd, mem_addr, instr, instr_addr,
//             instr_valid, halted)
//   slave  : the surrounding PC, ROM, decode and control logic
//            (drives en, pc_val, pc_max, mem_rdata, instr_ready)
// Parameters:
//   ADDR_W  : PC value / ROM address width
//   INSTR_W : instruction word width
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 8
);

  // Control / PC side
  logic               en;
  logic [ADDR_W-1:0]  pc_val;
  logic               pc_max;
  logic               pc_inc;

  // Program ROM side
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_rdata;

  // Decode side
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_addr;
  logic               instr_valid;
  logic               instr_ready;
  logic               halted;

  modport master (
    input  en, pc_val, pc_max, mem_rdata, instr_ready,
    output pc_inc, mem_rd, mem_addr, instr, instr_addr, instr_valid, halted
  );

  modport slave (
    output en, pc_val, pc_max, mem_rdata, instr_ready,
    input  pc_inc, mem_rd, mem_addr, instr, instr_addr, instr_valid, halted
  );

endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage between the program counter and decode. Reads the
// current PC, issues one read to the synchronous program ROM, captures the
// returned word into an instruction register, pulses the PC increment once
// per fetched word and offers the word to decode with a valid/ready
// handshake. Once the last address of the program space has been delivered
// (or the PC reports max size) the unit parks in HALT until reset.
// Ports:
//   clk  : system clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : fetch_unit_if master modport (PC, ROM and decode signals)
// Parameters:
//   ADDR_W  : PC value / ROM address width, equal to the PC size
//   INSTR_W : instruction word width
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 8
) (
  input  logic          clk,
  input  logic          rstn,
  fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    PRESENT,
    HALT
  } fetchState_t;

  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  fetchState_t        r_state;
  fetchState_t        w_nextState;
  logic [ADDR_W-1:0]  r_fetchAddr;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_instrAddr;
  logic               r_instrValid;
  logic               r_last;

  logic               w_memRd;
  logic               w_pcInc;
  logic               w_handshake;
  logic               w_atLastAddr;

  assign w_handshake  = r_instrValid && bus.instr_ready;
  assign w_atLastAddr = (r_fetchAddr == LastAddr);

  // State register. Reset drops straight back to IDLE from anywhere, which
  // also kills the combinational strobes immediately.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and strobe decode. pc_max outranks everything, then the end
  // of a handshake, then the run enable. The ROM read is only issued when the
  // PC still has room, and the PC is never bumped past the final address.
  always_comb begin
    w_nextState = r_state;
    w_memRd     = 1'b0;
    w_pcInc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.pc_max) begin
          w_nextState = HALT;
        end else if (bus.en) begin
          w_nextState = REQ;
        end
      end
      REQ: begin
        if (bus.pc_max) begin
          w_nextState = HALT;
        end else begin
          w_memRd     = 1'b1;
          w_nextState = WAIT;
        end
      end
      WAIT: begin
        w_pcInc     = !w_atLastAddr;
        w_nextState = PRESENT;
      end
      PRESENT: begin
        if (w_handshake) begin
          if (r_last || bus.pc_max) begin
            w_nextState = HALT;
          end else if (bus.en) begin
            w_nextState = REQ;
          end else begin
            w_nextState = IDLE;
          end
        end
      end
      HALT: begin
        w_nextState = HALT;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. The fetch address is captured alongside the read so
  // instr_addr matches the word even though the PC moves on during WAIT.
  // The last flag marks that the top of the program space has been fetched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetchAddr  <= '0;
      r_instr      <= '0;
      r_instrAddr  <= '0;
      r_instrValid <= 1'b0;
      r_last       <= 1'b0;
    end else begin
      case (r_state)
        REQ: begin
          if (!bus.pc_max) begin
            r_fetchAddr <= bus.pc_val;
          end
        end
        WAIT: begin
          r_instr      <= bus.mem_rdata;
          r_instrAddr  <= r_fetchAddr;
          r_instrValid <= 1'b1;
          if (w_atLastAddr) begin
            r_last <= 1'b1;
          end
        end
        PRESENT: begin
          if (w_handshake) begin
            r_instrValid <= 1'b0;
          end
        end
        default: begin
          r_instrValid <= 1'b0;
        end
      endcase
    end
  end

  // The address bus only carries the PC while a read is actually issued.
  assign bus.mem_rd      = w_memRd;
  assign bus.mem_addr    = w_memRd ? bus.pc_val : '0;
  assign bus.pc_inc      = w_pcInc;
  assign bus.instr       = r_instr;
  assign bus.instr_addr  = r_instrAddr;
  assign bus.instr_valid = r_instrValid;
  assign bus.halted      = (r_state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Models a 5-bit PC counter and a synchronous
// ROM holding a ^ 8'hA5 at address a, then walks through streaming fetch,
// backpressure, enable drop, running to the top address, pc_max and reset.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int AW = 5;
  localparam int IW = 8;

  logic clk;
  logic rstn;

  fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  int assertCount = 0;
  int failCount   = 0;
  int incCount    = 0;
  int rdCount     = 0;

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC model: counts up on pc_inc, cleared by the shared reset.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.pc_val <= '0;
    end else if (bus.pc_inc) begin
      bus.pc_val <= bus.pc_val + 1'b1;
    end
  end

  // Synchronous ROM model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_rdata <= {3'b000, bus.mem_addr} ^ 8'hA5;
    end
  end

  // Strobe counters sampled mid-cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.pc_inc) incCount++;
      if (bus.mem_rd) rdCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic enVal, input logic readyVal,
                               input logic pcMaxVal);
    bus.en          = enVal;
    bus.instr_ready = readyVal;
    bus.pc_max      = pcMaxVal;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rstn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    step();
    step();
    rstn = 1'b1;
  endtask

  function automatic logic [7:0] romWord(input int a);
    logic [7:0] addrByte;
    addrByte = 8'(a);
    return addrByte ^ 8'hA5;
  endfunction

  initial begin
    int startInc;
    int startRd;
    int found;
    int haltCycles;

    bus.mem_rdata = '0;
    doReset();

    // Reset values.
    checkOutput("rst_valid",  32'(bus.instr_valid), 32'd0);
    checkOutput("rst_pc_inc", 32'(bus.pc_inc),      32'd0);
    checkOutput("rst_mem_rd", 32'(bus.mem_rd),      32'd0);
    checkOutput("rst_halted", 32'(bus.halted),      32'd0);
    checkOutput("rst_instr",  32'(bus.instr),       32'd0);
    checkOutput("rst_iaddr",  32'(bus.instr_addr),  32'd0);
    checkOutput("rst_maddr",  32'(bus.mem_addr),    32'd0);

    // Streaming fetch of words 0..2 with decode always ready.
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int w = 0; w < 3; w++) begin
      step();
      checkOutput("req_mem_rd", 32'(bus.mem_rd),   32'd1);
      checkOutput("req_maddr",  32'(bus.mem_addr), 32'(w));
      checkOutput("req_pc_inc", 32'(bus.pc_inc),   32'd0);
      step();
      checkOutput("wait_pc_inc", 32'(bus.pc_inc), 32'd1);
      checkOutput("wait_mem_rd", 32'(bus.mem_rd), 32'd0);
      if (w == 2) applyStimulus(1'b1, 1'b0, 1'b0);
      step();
      checkOutput("pres_valid", 32'(bus.instr_valid), 32'd1);
      checkOutput("pres_instr", 32'(bus.instr),       32'(romWord(w)));
      checkOutput("pres_iaddr", 32'(bus.instr_addr),  32'(w));
    end
    checkOutput("stream_incs", 32'(incCount), 32'd3);
    checkOutput("stream_rds",  32'(rdCount),  32'd3);

    // Backpressure: ready low for 5 PRESENT cycles, then handshake.
    startInc = incCount;
    startRd  = rdCount;
    for (int c = 0; c < 4; c++) begin
      step();
      checkOutput("bp_valid",  32'(bus.instr_valid), 32'd1);
      checkOutput("bp_instr",  32'(bus.instr),       32'(romWord(2)));
      checkOutput("bp_iaddr",  32'(bus.instr_addr),  32'd2);
      checkOutput("bp_mem_rd", 32'(bus.mem_rd),      32'd0);
    end
    step();
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("bp_no_inc", 32'(incCount), 32'(startInc));
    checkOutput("bp_no_rd",  32'(rdCount),  32'(startRd));
    step();
    checkOutput("bp_next_rd",   32'(bus.mem_rd),   32'd1);
    checkOutput("bp_next_addr", 32'(bus.mem_addr), 32'd3);

    // Enable dropped during WAIT of address 3.
    step();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("endrop_pc_inc", 32'(bus.pc_inc), 32'd1);
    step();
    checkOutput("endrop_instr", 32'(bus.instr),      32'(romWord(3)));
    checkOutput("endrop_iaddr", 32'(bus.instr_addr), 32'd3);
    startRd = rdCount;
    for (int c = 0; c < 3; c++) step();
    checkOutput("idle_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("idle_no_rd", 32'(rdCount),         32'(startRd));
    checkOutput("idle_incs",  32'(incCount),        32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0);
    step();
    checkOutput("resume_rd",   32'(bus.mem_rd),   32'd1);
    checkOutput("resume_addr", 32'(bus.mem_addr), 32'd4);

    // Run to the top of the program space.
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      step();
      if (bus.instr_valid && bus.instr_addr == 5'd31) found = 1;
    end
    checkOutput("reach_31", 32'(found), 32'd1);
    checkOutput("top_instr", 32'(bus.instr), 32'(romWord(31)));
    checkOutput("top_incs",  32'(incCount),  32'd31);
    startRd = rdCount;
    step();
    checkOutput("top_halted", 32'(bus.halted),      32'd1);
    checkOutput("top_valid",  32'(bus.instr_valid), 32'd0);
    checkOutput("top_keep",   32'(bus.instr_addr),  32'd31);
    haltCycles = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.halted && !bus.mem_rd && !bus.pc_inc) haltCycles++;
    end
    checkOutput("halt_sticky", 32'(haltCycles), 32'd10);
    checkOutput("halt_no_rd",  32'(rdCount),    32'(startRd));
    checkOutput("halt_incs",   32'(incCount),   32'd31);

    // pc_max raised while in REQ.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("pcmax_no_rd", 32'(bus.mem_rd), 32'd0);
    step();
    checkOutput("pcmax_halted", 32'(bus.halted), 32'd1);

    // Reset pulsed during WAIT.
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0);
    step();
    step();
    checkOutput("rw_pre_inc", 32'(bus.pc_inc), 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("rw_pc_inc", 32'(bus.pc_inc),      32'd0);
    checkOutput("rw_valid",  32'(bus.instr_valid), 32'd0);
    checkOutput("rw_halted", 32'(bus.halted),      32'd0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    step();
    checkOutput("rw_req_rd",   32'(bus.mem_rd),   32'd1);
    checkOutput("rw_req_addr", 32'(bus.mem_addr), 32'd0);
    step();
    step();
    checkOutput("rw_instr", 32'(bus.instr),      32'(romWord(0)));
    checkOutput("rw_iaddr", 32'(bus.instr_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
